// File: rtl/bg_pe_pkg.sv
// Shared definitions for the bg_pe_stream background-removal PE: one-hot state
// encoding, default channel width and the pixel-slice helper.
package bg_pe_pkg;

    localparam int DEFAULT_CH_W = 8;

    // Widest window/channel the slice helper can address.
    localparam int MAX_BUS_W = 512;
    localparam int MAX_CH_W  = 16;

    localparam logic [6:0] ST_INI      = 7'b0000001;
    localparam logic [6:0] ST_SUM_INI  = 7'b0000010;
    localparam logic [6:0] ST_SUM      = 7'b0000100;
    localparam logic [6:0] ST_SUM_DONE = 7'b0001000;
    localparam logic [6:0] ST_BG_INI   = 7'b0010000;
    localparam logic [6:0] ST_BG       = 7'b0100000;
    localparam logic [6:0] ST_BG_DONE  = 7'b1000000;

    // Returns channel value of pixel k from a packed window (pixel k at [k*ch_w +: ch_w]).
    function automatic logic [MAX_CH_W-1:0] pix_slice(input logic [MAX_BUS_W-1:0] bus,
                                                      input int unsigned k,
                                                      input int unsigned ch_w);
        logic [MAX_CH_W-1:0] mask;
        mask = MAX_CH_W'((32'd1 << ch_w) - 32'd1);
        return MAX_CH_W'(bus >> (k * ch_w)) & mask;
    endfunction

endpackage

// File: rtl/bg_pe_stream_if.sv
// Host <-> PE bundle for bg_pe_stream: Start/Ack handshake, pixel windows,
// removal parameters, results and one-hot state flags.
interface bg_pe_stream_if
    import bg_pe_pkg::*;
#(
    parameter int NUM_PIXELS = 4,
    parameter int CH_W       = DEFAULT_CH_W
);
    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int SUM_W = CH_W + IDX_W;
    localparam int BUS_W = CH_W * NUM_PIXELS;

    // Start_* are levels sampled only in INI; Ack releases a DONE state on the edge it is seen.
    logic             Start_Sum;
    logic             Start_BgRemoval;
    logic             Ack;
    logic [BUS_W-1:0] red_in, green_in, blue_in;
    logic [CH_W-1:0]  red_exp, green_exp, blue_exp;
    logic [CH_W+1:0]  threshold;
    logic [CH_W-1:0]  desired_bg_r, desired_bg_g, desired_bg_b;

    logic [BUS_W-1:0] red_out, green_out, blue_out;
    logic [SUM_W-1:0] red_sum, green_sum, blue_sum;
    logic [CH_W-1:0]  red_mean, green_mean, blue_mean;
    logic             Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd;

    modport master (
        output Start_Sum, Start_BgRemoval, Ack,
        output red_in, green_in, blue_in, red_exp, green_exp, blue_exp,
        output threshold, desired_bg_r, desired_bg_g, desired_bg_b,
        input  red_out, green_out, blue_out, red_sum, green_sum, blue_sum,
        input  red_mean, green_mean, blue_mean,
        input  Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd
    );

    modport slave (
        input  Start_Sum, Start_BgRemoval, Ack,
        input  red_in, green_in, blue_in, red_exp, green_exp, blue_exp,
        input  threshold, desired_bg_r, desired_bg_g, desired_bg_b,
        output red_out, green_out, blue_out, red_sum, green_sum, blue_sum,
        output red_mean, green_mean, blue_mean,
        output Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd
    );

endinterface

// File: rtl/bg_pixel_match.sv
// Combinational background-colour match for one pixel.
// Build option: BG_MANHATTAN_EN selects the summed-distance rule instead of per-channel.
module bg_pixel_match
    import bg_pe_pkg::*;
#(
    parameter int CH_W = DEFAULT_CH_W
) (
    input  logic [CH_W-1:0] pix_r_i,
    input  logic [CH_W-1:0] pix_g_i,
    input  logic [CH_W-1:0] pix_b_i,
    input  logic [CH_W-1:0] exp_r_i,
    input  logic [CH_W-1:0] exp_g_i,
    input  logic [CH_W-1:0] exp_b_i,
    input  logic [CH_W+1:0] thr_i,
    output logic            match_o
);

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [CH_W-1:0] d_r, d_g, d_b;

    assign d_r = abs_diff(pix_r_i, exp_r_i);
    assign d_g = abs_diff(pix_g_i, exp_g_i);
    assign d_b = abs_diff(pix_b_i, exp_b_i);

`ifdef BG_MANHATTAN_EN
    // Two extra bits hold the sum of three CH_W-bit differences without overflow.
    logic [CH_W+1:0] dist;

    assign dist    = {2'b00, d_r} + {2'b00, d_g} + {2'b00, d_b};
    assign match_o = (dist <= thr_i);
`else
    assign match_o = ({2'b00, d_r} <= thr_i) &&
                     ({2'b00, d_g} <= thr_i) &&
                     ({2'b00, d_b} <= thr_i);
`endif

endmodule

// File: rtl/bg_pe_stream.sv
// Parametrised background-removal PE: per-channel sum/mean phase and removal phase,
// one pixel per clock. Build option: BG_MANHATTAN_EN (match rule, see bg_pixel_match).
module bg_pe_stream
    import bg_pe_pkg::*;
#(
    parameter int NUM_PIXELS = 4,
    parameter int CH_W       = DEFAULT_CH_W
) (
    input logic           Clk,
    input logic           Reset,
    bg_pe_stream_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam int SUM_W = CH_W + IDX_W;
    localparam int BUS_W = CH_W * NUM_PIXELS;

    logic [6:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_idx;

    logic [BUS_W-1:0] in_r_q, in_g_q, in_b_q;
    logic [BUS_W-1:0] out_r_q, out_g_q, out_b_q;
    logic [SUM_W-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [CH_W-1:0]  exp_r_q, exp_g_q, exp_b_q;
    logic [CH_W-1:0]  des_r_q, des_g_q, des_b_q;
    logic [CH_W+1:0]  thr_q;

    logic [CH_W-1:0]  cur_r, cur_g, cur_b;
    logic             cur_match;

    assign last_idx = (idx_q == IDX_W'(NUM_PIXELS - 1));

    assign cur_r = CH_W'(pix_slice(MAX_BUS_W'(in_r_q), 32'(idx_q), CH_W));
    assign cur_g = CH_W'(pix_slice(MAX_BUS_W'(in_g_q), 32'(idx_q), CH_W));
    assign cur_b = CH_W'(pix_slice(MAX_BUS_W'(in_b_q), 32'(idx_q), CH_W));

    bg_pixel_match #(.CH_W(CH_W)) u_match (
        .pix_r_i (cur_r),
        .pix_g_i (cur_g),
        .pix_b_i (cur_b),
        .exp_r_i (exp_r_q),
        .exp_g_i (exp_g_q),
        .exp_b_i (exp_b_q),
        .thr_i   (thr_q),
        .match_o (cur_match)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INI: begin
                // Sum wins when both starts are requested together.
                if (bus.Start_Sum)            state_d = ST_SUM_INI;
                else if (bus.Start_BgRemoval) state_d = ST_BG_INI;
            end
            ST_SUM_INI: begin
                idx_d   = '0;
                state_d = ST_SUM;
            end
            ST_SUM: begin
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                if (last_idx) state_d = ST_SUM_DONE;
            end
            ST_SUM_DONE: if (bus.Ack) state_d = ST_INI;
            ST_BG_INI: begin
                idx_d   = '0;
                state_d = ST_BG;
            end
            ST_BG: begin
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                if (last_idx) state_d = ST_BG_DONE;
            end
            ST_BG_DONE: if (bus.Ack) state_d = ST_INI;
            default: begin
                state_d = ST_INI;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_INI;
            idx_q   <= '0;
            in_r_q  <= '0;
            in_g_q  <= '0;
            in_b_q  <= '0;
            out_r_q <= '0;
            out_g_q <= '0;
            out_b_q <= '0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            exp_r_q <= '0;
            exp_g_q <= '0;
            exp_b_q <= '0;
            des_r_q <= '0;
            des_g_q <= '0;
            des_b_q <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            case (state_q)
                ST_INI: begin
                    if (state_d != ST_INI) begin
                        in_r_q <= bus.red_in;
                        in_g_q <= bus.green_in;
                        in_b_q <= bus.blue_in;
                    end
                end
                ST_SUM_INI: begin
                    sum_r_q <= '0;
                    sum_g_q <= '0;
                    sum_b_q <= '0;
                end
                ST_SUM: begin
                    sum_r_q <= sum_r_q + SUM_W'(cur_r);
                    sum_g_q <= sum_g_q + SUM_W'(cur_g);
                    sum_b_q <= sum_b_q + SUM_W'(cur_b);
                end
                ST_BG_INI: begin
                    exp_r_q <= bus.red_exp;
                    exp_g_q <= bus.green_exp;
                    exp_b_q <= bus.blue_exp;
                    thr_q   <= bus.threshold;
                    des_r_q <= bus.desired_bg_r;
                    des_g_q <= bus.desired_bg_g;
                    des_b_q <= bus.desired_bg_b;
                end
                ST_BG: begin
                    out_r_q[int'(idx_q) * CH_W +: CH_W] <= cur_match ? des_r_q : cur_r;
                    out_g_q[int'(idx_q) * CH_W +: CH_W] <= cur_match ? des_g_q : cur_g;
                    out_b_q[int'(idx_q) * CH_W +: CH_W] <= cur_match ? des_b_q : cur_b;
                end
                default: ;
            endcase
        end
    end

    assign bus.red_out    = out_r_q;
    assign bus.green_out  = out_g_q;
    assign bus.blue_out   = out_b_q;
    assign bus.red_sum    = sum_r_q;
    assign bus.green_sum  = sum_g_q;
    assign bus.blue_sum   = sum_b_q;
    assign bus.red_mean   = CH_W'(sum_r_q >> IDX_W);
    assign bus.green_mean = CH_W'(sum_g_q >> IDX_W);
    assign bus.blue_mean  = CH_W'(sum_b_q >> IDX_W);

    assign bus.Qi   = state_q[0];
    assign bus.Qsi  = state_q[1];
    assign bus.Qs   = state_q[2];
    assign bus.Qsd  = state_q[3];
    assign bus.Qbgi = state_q[4];
    assign bus.Qbg  = state_q[5];
    assign bus.Qbgd = state_q[6];

endmodule

// File: tb/tb_bg_pe_stream.sv
// Directed bench for bg_pe_stream (NUM_PIXELS=4, CH_W=8): table of full-window
// vectors plus hand sequences for priority, Ack hold and mid-phase reset.
module tb_bg_pe_stream;

    localparam int NP    = 4;
    localparam int CW    = 8;
    localparam int LAT   = NP + 2;
    localparam int BOUND = 50;

    logic Clk;
    logic Reset;

    bg_pe_stream_if #(.NUM_PIXELS(NP), .CH_W(CW)) bus ();

    bg_pe_stream #(.NUM_PIXELS(NP), .CH_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] r_in, g_in, b_in;
        logic [7:0]  er, eg, eb;
        logic [9:0]  thr;
        logic [7:0]  dr, dg, db;
        logic [9:0]  sr, sg, sb;
        logic [7:0]  mr, mg, mb;
        logic [31:0] o_r, o_g, o_b;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] pack4(input logic [7:0] p0, input logic [7:0] p1,
                                          input logic [7:0] p2, input logic [7:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        bus.red_in       = v.r_in;
        bus.green_in     = v.g_in;
        bus.blue_in      = v.b_in;
        bus.red_exp      = v.er;
        bus.green_exp    = v.eg;
        bus.blue_exp     = v.eb;
        bus.threshold    = v.thr;
        bus.desired_bg_r = v.dr;
        bus.desired_bg_g = v.dg;
        bus.desired_bg_b = v.db;
    endtask

    // Called at a negedge; counts edges from the Start-sampling edge (edge 1) until a DONE flag shows.
    task automatic pulse_start(input logic s_sum, input logic s_bg, output int edges);
        bus.Start_Sum       = s_sum;
        bus.Start_BgRemoval = s_bg;
        @(posedge Clk);
        edges = 1;
        @(negedge Clk);
        bus.Start_Sum       = 1'b0;
        bus.Start_BgRemoval = 1'b0;
        while (!(bus.Qsd || bus.Qbgd) && edges < BOUND) begin
            @(posedge Clk);
            edges++;
            @(negedge Clk);
        end
    endtask

    task automatic check_sums(input string tag, input vec_t v);
        check({tag, " red_sum"},    32'(bus.red_sum),    32'(v.sr));
        check({tag, " green_sum"},  32'(bus.green_sum),  32'(v.sg));
        check({tag, " blue_sum"},   32'(bus.blue_sum),   32'(v.sb));
        check({tag, " red_mean"},   32'(bus.red_mean),   32'(v.mr));
        check({tag, " green_mean"}, 32'(bus.green_mean), 32'(v.mg));
        check({tag, " blue_mean"},  32'(bus.blue_mean),  32'(v.mb));
    endtask

    task automatic check_outs(input string tag, input logic [31:0] r,
                              input logic [31:0] g, input logic [31:0] b);
        check({tag, " red_out"},   bus.red_out,   r);
        check({tag, " green_out"}, bus.green_out, g);
        check({tag, " blue_out"},  bus.blue_out,  b);
    endtask

    task automatic check_qflags(input string tag, input logic [6:0] exp);
        check({tag, " Q flags"},
              32'({bus.Qbgd, bus.Qbg, bus.Qbgi, bus.Qsd, bus.Qs, bus.Qsi, bus.Qi}), 32'(exp));
    endtask

    task automatic run_bg(input string tag, input vec_t v);
        int edges;
        load_vec(v);
        pulse_start(1'b0, 1'b1, edges);
        check({tag, " bg latency"}, 32'(edges), 32'(LAT));
        check_outs(tag, v.o_r, v.o_g, v.o_b);
        @(negedge Clk);
        check_qflags({tag, " after bg ack"}, 7'b0000001);
    endtask

    initial begin
        logic [31:0] prev_r, prev_g, prev_b;
        int          edges;
        int          held;

        // Window from the reference pe: pixel0 differs, pixels 1-3 are background.
        vecs[0].r_in = pack4(8'd204, 8'd61, 8'd61, 8'd61);
        vecs[0].g_in = pack4(8'd0, 8'd133, 8'd133, 8'd133);
        vecs[0].b_in = pack4(8'd0, 8'd198, 8'd198, 8'd198);
        vecs[0].er = 8'd61; vecs[0].eg = 8'd133; vecs[0].eb = 8'd198; vecs[0].thr = 10'd60;
        vecs[0].dr = 8'd106; vecs[0].dg = 8'd168; vecs[0].db = 8'd79;
        vecs[0].sr = 10'd387; vecs[0].sg = 10'd399; vecs[0].sb = 10'd594;
        vecs[0].mr = 8'd96; vecs[0].mg = 8'd99; vecs[0].mb = 8'd148;
        vecs[0].o_r = pack4(8'd204, 8'd106, 8'd106, 8'd106);
        vecs[0].o_g = pack4(8'd0, 8'd168, 8'd168, 8'd168);
        vecs[0].o_b = pack4(8'd0, 8'd79, 8'd79, 8'd79);

        // Rule-sensitive window: p0 diffs (30,30,10), p2 diffs (60,60,40), p3 far.
        vecs[1].r_in = pack4(8'd91, 8'd61, 8'd121, 8'd0);
        vecs[1].g_in = pack4(8'd163, 8'd133, 8'd193, 8'd255);
        vecs[1].b_in = pack4(8'd208, 8'd198, 8'd238, 8'd10);
        vecs[1].er = 8'd61; vecs[1].eg = 8'd133; vecs[1].eb = 8'd198; vecs[1].thr = 10'd60;
        vecs[1].dr = 8'd1; vecs[1].dg = 8'd2; vecs[1].db = 8'd3;
        vecs[1].sr = 10'd273; vecs[1].sg = 10'd744; vecs[1].sb = 10'd654;
        vecs[1].mr = 8'd68; vecs[1].mg = 8'd186; vecs[1].mb = 8'd163;
`ifdef BG_MANHATTAN_EN
        vecs[1].o_r = pack4(8'd91, 8'd1, 8'd121, 8'd0);
        vecs[1].o_g = pack4(8'd163, 8'd2, 8'd193, 8'd255);
        vecs[1].o_b = pack4(8'd208, 8'd3, 8'd238, 8'd10);
`else
        vecs[1].o_r = pack4(8'd1, 8'd1, 8'd1, 8'd0);
        vecs[1].o_g = pack4(8'd2, 8'd2, 8'd2, 8'd255);
        vecs[1].o_b = pack4(8'd3, 8'd3, 8'd3, 8'd10);
`endif

        // Full-width threshold 1023: every pixel matches under either rule.
        vecs[2].r_in = pack4(8'd255, 8'd0, 8'd10, 8'd255);
        vecs[2].g_in = pack4(8'd0, 8'd255, 8'd20, 8'd255);
        vecs[2].b_in = pack4(8'd128, 8'd7, 8'd30, 8'd255);
        vecs[2].er = 8'd0; vecs[2].eg = 8'd0; vecs[2].eb = 8'd0; vecs[2].thr = 10'd1023;
        vecs[2].dr = 8'd9; vecs[2].dg = 8'd8; vecs[2].db = 8'd7;
        vecs[2].sr = 10'd520; vecs[2].sg = 10'd530; vecs[2].sb = 10'd420;
        vecs[2].mr = 8'd130; vecs[2].mg = 8'd132; vecs[2].mb = 8'd105;
        vecs[2].o_r = pack4(8'd9, 8'd9, 8'd9, 8'd9);
        vecs[2].o_g = pack4(8'd8, 8'd8, 8'd8, 8'd8);
        vecs[2].o_b = pack4(8'd7, 8'd7, 8'd7, 8'd7);

        // Zero threshold: exact colour only, one-off neighbours kept.
        vecs[3].r_in = pack4(8'd50, 8'd51, 8'd50, 8'd49);
        vecs[3].g_in = pack4(8'd60, 8'd60, 8'd60, 8'd60);
        vecs[3].b_in = pack4(8'd70, 8'd70, 8'd70, 8'd70);
        vecs[3].er = 8'd50; vecs[3].eg = 8'd60; vecs[3].eb = 8'd70; vecs[3].thr = 10'd0;
        vecs[3].dr = 8'd200; vecs[3].dg = 8'd201; vecs[3].db = 8'd202;
        vecs[3].sr = 10'd200; vecs[3].sg = 10'd240; vecs[3].sb = 10'd280;
        vecs[3].mr = 8'd50; vecs[3].mg = 8'd60; vecs[3].mb = 8'd70;
        vecs[3].o_r = pack4(8'd200, 8'd51, 8'd200, 8'd49);
        vecs[3].o_g = pack4(8'd201, 8'd60, 8'd201, 8'd60);
        vecs[3].o_b = pack4(8'd202, 8'd70, 8'd202, 8'd70);

        // Reset and idle
        bus.Start_Sum       = 1'b0;
        bus.Start_BgRemoval = 1'b0;
        bus.Ack             = 1'b1;
        load_vec(vecs[0]);
        Reset = 1'b1;
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check_qflags("reset", 7'b0000001);
        check_outs("reset", 32'd0, 32'd0, 32'd0);
        check("reset red_sum", 32'(bus.red_sum), 32'd0);
        check("reset blue_mean", 32'(bus.blue_mean), 32'd0);
        repeat (3) @(negedge Clk);
        check_qflags("idle no start", 7'b0000001);

        prev_r = '0;
        prev_g = '0;
        prev_b = '0;
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            load_vec(vecs[i]);
            pulse_start(1'b1, 1'b0, edges);
            check({tag, " sum latency"}, 32'(edges), 32'(LAT));
            check_sums(tag, vecs[i]);
            check_outs({tag, " after sum"}, prev_r, prev_g, prev_b);
            @(negedge Clk);
            check_qflags({tag, " Qsd one cycle"}, 7'b0000001);
            run_bg(tag, vecs[i]);
            check_sums({tag, " after bg"}, vecs[i]);
            prev_r = vecs[i].o_r;
            prev_g = vecs[i].o_g;
            prev_b = vecs[i].o_b;
        end

        // Both starts together, then Ack held low with stray starts
        bus.Ack = 1'b0;
        load_vec(vecs[0]);
        bus.Start_Sum       = 1'b1;
        bus.Start_BgRemoval = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start_Sum       = 1'b0;
        bus.Start_BgRemoval = 1'b0;
        check_qflags("priority sum_ini", 7'b0000010);
        edges = 0;
        while (!bus.Qsd && edges < BOUND) begin
            @(negedge Clk);
            edges++;
        end
        check("priority reached sum_done", 32'(bus.Qsd), 32'd1);
        held = 0;
        for (int c = 0; c < 10; c++) begin
            bus.Start_BgRemoval = c[0];
            bus.Start_Sum       = ~c[0];
            @(negedge Clk);
            if (bus.Qsd) held++;
        end
        bus.Start_Sum       = 1'b0;
        bus.Start_BgRemoval = 1'b0;
        check("Qsd held while Ack low", 32'(held), 32'd10);
        check_sums("hold", vecs[0]);
        check_outs("hold", vecs[3].o_r, vecs[3].o_g, vecs[3].o_b);
        bus.Ack = 1'b1;
        @(negedge Clk);
        check_qflags("ack release", 7'b0000001);

        // Asynchronous reset during removal at idx 2
        load_vec(vecs[1]);
        bus.Start_BgRemoval = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus.Start_BgRemoval = 1'b0;
        repeat (3) @(negedge Clk);
        check_qflags("mid bg", 7'b0100000);
        Reset = 1'b1;
        #1;
        check_qflags("async reset", 7'b0000001);
        check_outs("async reset", 32'd0, 32'd0, 32'd0);
        check("async reset red_sum", 32'(bus.red_sum), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_bg("post reset", vecs[0]);
        check("post reset green_sum", 32'(bus.green_sum), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_pe_stream.md
Name: bg_pe_stream

Overview:
Parametrised background-removal processing element, the successor to the fixed 4-pixel pe.
- Sum phase: accumulates per-channel sums and means over a NUM_PIXELS pixel window.
- Removal phase: replaces every pixel whose colour matches the expected background (within a threshold) with a desired background colour.
- Processes one pixel per clock using an index counter, and buffers both input and output windows.
- A host sequencer drives it with Start/Ack handshakes; several instances run side by side and the host combines their means.

Parameters:
NUM_PIXELS, 4, pixels per window; must be a power of two, >=2
CH_W, 8, bits per colour channel
IDX_W, $clog2(NUM_PIXELS), pixel index counter width (derived)
SUM_W, CH_W+IDX_W, accumulator width (derived; cannot overflow)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start_Sum  in  1  request sum phase; sampled only in INI
Start_BgRemoval  in  1  request removal phase; sampled only in INI
Ack  in  1  host acknowledge; releases a DONE state
red_in/green_in/blue_in  in  CH_W*NUM_PIXELS each  pixel window; pixel k at [k*CH_W +: CH_W]
red_exp/green_exp/blue_exp  in  CH_W each  expected background colour
threshold  in  CH_W+2  match threshold, unsigned
desired_bg_r/g/b  in  CH_W each  replacement colour
red_out/green_out/blue_out  out  CH_W*NUM_PIXELS each  processed window
red_sum/green_sum/blue_sum  out  SUM_W each  channel sums
red_mean/green_mean/blue_mean  out  CH_W each  sum >> IDX_W (truncating)
Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd  out  1 each  one-hot state flags

Behaviour:
- Reset (async, any state, including mid-phase):
  - State goes to INI and the index counter clears to 0.
  - All sums, means, the output window and the input buffer clear to 0.
  - Qi=1; all other Q flags are 0.
- States: INI, SUM_INI, SUM, SUM_DONE, BG_INI, BG, BG_DONE. The matching Q flag is high; exactly one flag is high at any time.
- INI transitions:
  - Start_Sum=1 -> SUM_INI. Start_Sum has priority if both Starts are high.
  - Else Start_BgRemoval=1 -> BG_INI.
  - On either transition, the pixel buses are latched into the internal input buffer.
  - Both Starts are ignored in every other state.
- SUM_INI (1 cycle): clear accumulators and the index counter -> SUM.
- SUM: each cycle, add buffered pixel[idx] to each accumulator and increment idx. On idx==NUM_PIXELS-1, add the final pixel, then -> SUM_DONE.
- SUM_DONE:
  - Sum outputs are valid and means = sum >> IDX_W.
  - Stay while Ack=0; Ack=1 -> INI at the next edge.
  - If Ack is held high, Qsd lasts exactly one cycle.
- Sum latency: Qsd rises NUM_PIXELS+2 edges after the edge that samples Start_Sum.
- BG_INI (1 cycle): latch exp, threshold and desired colour; clear idx -> BG.
- BG: each cycle, compute the match for pixel[idx] and write its slot in the output window. On the last index -> BG_DONE.
  - Match: out = desired colour; no match: out = input pixel, unchanged.
  - Output slots that are not yet written keep their previous values.
  - Latency matches the sum phase.
- BG_DONE: Ack handshake identical to SUM_DONE. Outputs hold until a new phase overwrites them.
- Match rule (default): |r-r_exp|<=thr AND |g-g_exp|<=thr AND |b-b_exp|<=thr.
  - Absolute differences are CH_W bits, unsigned.
  - threshold is compared at full CH_W+2 width.
- Phase independence: sums and means are unaffected by the removal phase, and the output window is unaffected by the sum phase.

Optional Feature:
BG_MANHATTAN_EN
- Defined: match when |dr|+|dg|+|db| (CH_W+2 bits, no overflow) <= threshold.
- Undefined: the per-channel AND rule above.
- Ports and timing are identical in both builds.

Decomposition:
- Package bg_pe_pkg holds:
  - state encoding constants (one-hot, 7 bits)
  - the pixel-slice helper function
  - default CH_W
- Sub-module bg_pixel_match (combinational): inputs are pixel, exp and threshold; output is the match bit. It contains the abs-difference logic and the BG_MANHATTAN_EN selection.

Test Plan:
1. Reset held 5 cycles, then released -> Qi=1, all outputs 0; no transition while both Starts are low.
2. Sum phase:
   - Stimulus: pixel0=(204,0,0), pixels1-3=(61,133,198), Start_Sum for 1 cycle, Ack=1.
   - Response: sums=(387,399,594), means=(96,99,148).
   - Qsd high for exactly 1 cycle, NUM_PIXELS+2 edges after Start.
3. Removal phase:
   - Stimulus: same window, exp=(61,133,198), thr=60, desired=(106,168,79).
   - Response: pixel0 output=(204,0,0); pixels1-3 output=(106,168,79); Qbgd asserts.
4. Match rule: pixel=(91,163,208), exp=(61,133,198), thr=60.
   - Default build: replaced.
   - With BG_MANHATTAN_EN: kept (difference sum 70 > 60).
5. Handshake and priority:
   - Both Starts asserted together -> SUM_INI taken.
   - Ack=0 in SUM_DONE for 10 cycles -> Qsd held, and Start pulses are ignored.
   - Ack=1 -> Qi=1 next cycle.
6. Reset mid-phase: Reset asserted during BG at idx=2 -> immediate Qi=1 (asynchronous), outputs cleared. The next removal phase completes normally.
